fc_class_accum: RTL and testbench
=================================

// Module: fc_class_accum
// PURPOSE
//   Final fully-connected classifier stage of the CNN accelerator. Accepts a stream of
//   signed activations, each paired with a vector of per-class weights, and accumulates
//   NUM_CLASS dot products in parallel. At end of frame it adds per-class bias and
//   saturates to OUT_W bits. It then presents all class scores with a one-cycle valid
//   pulse to the downstream argmax stage (o_data -> i_data, o_valid -> i_pre_valid).
// PARAMETERS
//   NUM_CLASS  10   number of output classes / parallel accumulators
//   IN_LEN     120  activations per frame (FC input length)
//   DATA_W     8    activation width, signed
//   W_W        8    weight width, signed
//   ACC_W      40   internal accumulator width, signed; must be >= OUT_W+1
//   OUT_W      32   output score width, signed
//   CNT_W      $clog2(IN_LEN+1)  beat counter width (derived)
// PORTS
//   i_clk       in   1                   clock
//   i_rstn      in   1                   synchronous, active-low reset
//   i_act       in   DATA_W              activation beat, signed
//   i_weight    in   W_W x NUM_CLASS     per-class weights for this beat (unpacked [NUM_CLASS-1:0])
//   i_act_valid in   1                   beat valid
//   i_act_last  in   1                   final beat of frame
//   o_act_ready out  1                   stage can accept a beat
//   i_bias      in   OUT_W x NUM_CLASS   per-class bias, signed; static for the whole frame
//   o_data      out  OUT_W x NUM_CLASS   class scores, signed; held until next o_valid
//   o_valid     out  1                   1-cycle pulse: o_data updated
//   o_len_err   out  1                   qualifies o_valid: frame length != IN_LEN
// BEHAVIOUR
//   Reset (i_rstn=0 at posedge): state=RUN, all accumulators, o_data, o_valid, o_len_err
//     and the beat counter = 0; product pipeline cleared; o_act_ready=0 while i_rstn=0.
//   Reset mid-frame: partial frame discarded; no o_valid is produced for it.
//   States: RUN -> DRAIN -> BIAS -> OUT -> RUN.
//   Handshake: beat accepted when i_act_valid && o_act_ready.
//     o_act_ready = (state==RUN) && i_rstn.
//   RUN: on accept, prod[k] <= i_act*i_weight[k] (DATA_W+W_W signed, registered);
//     cnt++. The previous cycle's registered product is added into acc[k]
//     (sign-extended to ACC_W).
//   End of frame: an accepted beat is the final beat if i_act_last=1, or if it is
//     beat number IN_LEN (cnt==IN_LEN-1 before increment), whichever comes first.
//     On the final beat: state->DRAIN; len_err latched = (count of accepted beats != IN_LEN).
//   DRAIN: last registered product added into acc; state->BIAS.
//   BIAS: acc[k] += sign-extended i_bias[k]; state->OUT.
//   OUT: o_data[k] <= sat(acc[k]), clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//     o_valid<=1 and o_len_err<=len_err for one cycle.
//     acc, cnt and len_err cleared; state->RUN.
//   Latency: final beat accepted in cycle T -> o_valid high in cycle T+4.
//     o_act_ready low in T+1..T+3 and high again in T+4.
//     Minimum frame period is IN_LEN+3 cycles.
//   Accumulation is exact within ACC_W (no wrap for IN_LEN<=2^(ACC_W-16-1)).
//     Saturation is applied only at OUT.
//   o_data changes only in the cycle o_valid is high; no other output glitches.
//   i_act_last on a non-accepted cycle is ignored. i_act_valid is ignored outside RUN.
// TESTING
//   1. act=1, weight[k]=k+1 for 120 beats, last on beat 120, bias=0
//      -> o_data[k]=120*(k+1); o_len_err=0; o_valid 4 cycles after last accept.
//   2. act=-128, weight[k]=-128 for 120 beats, bias[k]=2^31-1
//      -> every o_data saturates to 32'h7FFF_FFFF.
//      Also: act=-128, weight=127, bias=-2^31 -> 32'h8000_0000.
//   3. last asserted on beat 50 (act=2, weights=3)
//      -> o_data=300+bias, o_len_err=1. Repeat with no last: frame closes at beat 120,
//         o_len_err=0. Repeat with last first asserted on beat 121: frame closes at
//         beat 120 and o_len_err=0; the next frame starts with beat 121.
//   4. random valid gaps (50% duty) with back-to-back frames
//      -> scores match the reference model; o_act_ready low for exactly 3 cycles per frame.
//   5. i_rstn pulsed low at beat 60, then a full frame is sent
//      -> no o_valid for the aborted frame; the next result equals the clean-frame result.
//   6. two frames with distinct scores
//      -> o_data holds frame-1 values until the frame-2 o_valid; a downstream argmax
//         connected to o_data/o_valid picks the planted winner (class 7 = max).

Source files
------------

// File: rtl/fc_class_accum.sv
// Final fully-connected classifier stage: NUM_CLASS parallel signed MACs over a
// frame of activations, then per-class bias, saturation to OUT_W and a one-cycle
// valid pulse presenting all class scores to the downstream argmax.
module fc_class_accum #(
  parameter int NUM_CLASS = 10,
  parameter int IN_LEN    = 120,
  parameter int DATA_W    = 8,
  parameter int W_W       = 8,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 32,
  parameter int CNT_W     = $clog2(IN_LEN + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic signed [DATA_W-1:0] i_act,
  input  logic signed [W_W-1:0]   i_weight [NUM_CLASS-1:0],
  input  logic                    i_act_valid,
  input  logic                    i_act_last,
  output logic                    o_act_ready,
  input  logic signed [OUT_W-1:0] i_bias   [NUM_CLASS-1:0],
  output logic signed [OUT_W-1:0] o_data   [NUM_CLASS-1:0],
  output logic                    o_valid,
  output logic                    o_len_err
);

  localparam int PROD_W = DATA_W + W_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_LEN - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_BIAS,
    S_OUT
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     len_err;
  logic                     prod_vld;
  logic signed [PROD_W-1:0] prod [NUM_CLASS-1:0];
  logic signed [ACC_W-1:0]  acc  [NUM_CLASS-1:0];
  logic                     accept;
  logic                     final_beat;

  assign o_act_ready = (state == S_RUN) && i_rstn;
  assign accept      = i_act_valid && o_act_ready;
  // A frame closes on an explicit last or on beat IN_LEN, whichever comes first.
  assign final_beat  = i_act_last || (cnt == LAST_IDX);

  // Clamp a wide accumulator into the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-OUT_W:0] top;
    top = v[ACC_W-1:OUT_W-1];
    if ((&top) || !(|top)) begin
      sat = v[OUT_W-1:0];
    end else if (v[ACC_W-1]) begin
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  // Frame sequencer with product pipeline, accumulators and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= S_RUN;
      cnt       <= '0;
      len_err   <= 1'b0;
      prod_vld  <= 1'b0;
      o_valid   <= 1'b0;
      o_len_err <= 1'b0;
      for (int unsigned k = 0; k < NUM_CLASS; k++) begin
        prod[k]   <= '0;
        acc[k]    <= '0;
        o_data[k] <= '0;
      end
    end else begin
      o_valid   <= 1'b0;
      o_len_err <= 1'b0;
      case (state)
        S_RUN: begin
          // Products are registered one cycle ahead of the accumulate.
          for (int unsigned k = 0; k < NUM_CLASS; k++) begin
            if (prod_vld) acc[k] <= acc[k] + ACC_W'(prod[k]);
          end
          prod_vld <= accept;
          if (accept) begin
            for (int unsigned k = 0; k < NUM_CLASS; k++) begin
              prod[k] <= PROD_W'(i_act) * PROD_W'(i_weight[k]);
            end
            cnt <= cnt + CNT_W'(1);
            if (final_beat) begin
              state   <= S_DRAIN;
              len_err <= (cnt != LAST_IDX);
            end
          end
        end
        S_DRAIN: begin
          for (int unsigned k = 0; k < NUM_CLASS; k++) begin
            if (prod_vld) acc[k] <= acc[k] + ACC_W'(prod[k]);
          end
          prod_vld <= 1'b0;
          state    <= S_BIAS;
        end
        S_BIAS: begin
          for (int unsigned k = 0; k < NUM_CLASS; k++) begin
            acc[k] <= acc[k] + ACC_W'(i_bias[k]);
          end
          state <= S_OUT;
        end
        S_OUT: begin
          for (int unsigned k = 0; k < NUM_CLASS; k++) begin
            o_data[k] <= sat(acc[k]);
            acc[k]    <= '0;
          end
          o_valid   <= 1'b1;
          o_len_err <= len_err;
          cnt       <= '0;
          len_err   <= 1'b0;
          state     <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_class_accum.sv
// Self-checking bench for fc_class_accum: frame-level reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_fc_class_accum;

  localparam int NUM_CLASS = 10;
  localparam int IN_LEN    = 120;
  localparam longint SMAX  = (longint'(1) <<< 31) - 1;
  localparam longint SMIN  = -(longint'(1) <<< 31);

  typedef logic signed [7:0]  w_arr_t [NUM_CLASS-1:0];

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic signed [7:0]  act = '0;
  logic signed [7:0]  weight [NUM_CLASS-1:0];
  logic               act_valid = 1'b0;
  logic               act_last = 1'b0;
  logic               act_ready;
  logic signed [31:0] bias   [NUM_CLASS-1:0];
  logic signed [31:0] o_data [NUM_CLASS-1:0];
  logic               o_valid;
  logic               o_len_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_results = 0;
  int res_cyc = 0;
  int last_acc_cyc = 0;
  logic signed [31:0] cap_data [NUM_CLASS-1:0];
  logic               cap_err;

  // reference model state (frame-level)
  longint sum [NUM_CLASS];
  longint pend_data [NUM_CLASS];
  int     nbeat = 0;
  int     busy = 0;
  int     pend = 0;
  bit     pend_err = 0;
  logic signed [31:0] m_data [NUM_CLASS-1:0];
  bit     m_valid = 0;
  bit     m_err = 0;

  fc_class_accum #(.NUM_CLASS(NUM_CLASS), .IN_LEN(IN_LEN), .DATA_W(8), .W_W(8),
                   .ACC_W(40), .OUT_W(32)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_act(act), .i_weight(weight),
    .i_act_valid(act_valid), .i_act_last(act_last), .o_act_ready(act_ready),
    .i_bias(bias), .o_data(o_data), .o_valid(o_valid), .o_len_err(o_len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic longint clamp(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  initial begin
    for (int k = 0; k < NUM_CLASS; k++) begin
      weight[k] = '0; bias[k] = '0; m_data[k] = '0; sum[k] = 0; pend_data[k] = 0;
    end
  end

  // per-cycle compare against the model, then advance the model one cycle
  always @(negedge clk) begin
    bit bad;
    bit acc_now;
    checks++;
    if (o_valid !== m_valid) begin
      failures++; $display("FAIL o_valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_valid);
    end
    checks++;
    if (o_len_err !== m_err) begin
      failures++; $display("FAIL o_len_err cyc=%0d got=%b exp=%b", cyc, o_len_err, m_err);
    end
    checks++;
    if (act_ready !== (rstn === 1'b1 && busy == 0)) begin
      failures++; $display("FAIL o_act_ready cyc=%0d got=%b exp=%b", cyc, act_ready, (rstn === 1'b1 && busy == 0));
    end
    bad = 0;
    for (int k = 0; k < NUM_CLASS; k++) if (o_data[k] !== m_data[k]) bad = 1;
    checks++;
    if (bad) begin
      failures++;
      for (int k = 0; k < NUM_CLASS; k++)
        if (o_data[k] !== m_data[k]) $display("FAIL o_data[%0d] cyc=%0d got=%0d exp=%0d", k, cyc, o_data[k], m_data[k]);
    end
    if (o_valid === 1'b1) begin
      for (int k = 0; k < NUM_CLASS; k++) cap_data[k] = o_data[k];
      cap_err = o_len_err;
      res_cyc = cyc;
      n_results++;
    end
    if (rstn !== 1'b1) begin
      for (int k = 0; k < NUM_CLASS; k++) begin sum[k] = 0; m_data[k] = '0; end
      nbeat = 0; busy = 0; pend = 0; m_valid = 0; m_err = 0;
    end else begin
      m_valid = 0; m_err = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_valid = 1; m_err = pend_err;
          for (int k = 0; k < NUM_CLASS; k++) m_data[k] = 32'(pend_data[k]);
        end
      end
      acc_now = (act_valid === 1'b1) && busy == 0;
      if (busy > 0) busy--;
      if (acc_now) begin
        nbeat++;
        for (int k = 0; k < NUM_CLASS; k++) sum[k] += longint'(act) * longint'(weight[k]);
        if (act_last === 1'b1 || nbeat == IN_LEN) begin
          for (int k = 0; k < NUM_CLASS; k++) begin
            pend_data[k] = clamp(sum[k] + longint'(bias[k]));
            sum[k] = 0;
          end
          pend_err = (nbeat != IN_LEN);
          nbeat = 0; busy = 3; pend = 3;
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++; $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic send_beat(input logic signed [7:0] a, input w_arr_t w, input bit last, input bit gaps);
    bit ok;
    ok = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        act_valid = 0; act_last = 1'($urandom); act = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    act = a; weight = w; act_last = last; act_valid = 1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = (act_ready === 1'b1);
      if (ok) last_acc_cyc = cyc;
      @(posedge clk); #1;
    end
    act_valid = 0; act_last = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL beat_accept got=timeout exp=ready"); end
  endtask

  task automatic send_frame(input logic signed [7:0] a, input w_arr_t w, input int n, input int last_at, input bit gaps);
    for (int i = 1; i <= n; i++) send_beat(a, w, (i == last_at), gaps);
  endtask

  task automatic wait_result(input int prev);
    bit ok;
    ok = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(posedge clk); #1;
      ok = (n_results != prev);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL result_wait got=timeout exp=o_valid"); end
  endtask

  function automatic int argmax();
    int best;
    best = 0;
    for (int k = 1; k < NUM_CLASS; k++) if (cap_data[k] > cap_data[best]) best = k;
    return best;
  endfunction

  initial begin
    w_arr_t w;
    int prev;
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_arr_t w;
    int prev;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", longint'(o_valid), 0);
    chk("reset_data0", longint'(o_data[0]), 0);
    chk("reset_ready", longint'(act_ready), 0);
    rstn = 1;

    // 1: ramp weights, act=1, explicit last on beat 120
    for (int k = 0; k < NUM_CLASS; k++) begin w[k] = 8'(k + 1); bias[k] = '0; end
    prev = n_results;
    send_frame(8'sd1, w, IN_LEN, IN_LEN, 0);
    wait_result(prev);
    for (int k = 0; k < NUM_CLASS; k++) chk("t1_data", longint'(cap_data[k]), 120 * (k + 1));
    chk("t1_len_err", longint'(cap_err), 0);
    chk("t1_latency", longint'(res_cyc - last_acc_cyc), 4);

    // 2: positive and negative saturation
    for (int k = 0; k < NUM_CLASS; k++) begin w[k] = -8'sd128; bias[k] = 32'sh7FFF_FFFF; end
    prev = n_results;
    send_frame(-8'sd128, w, IN_LEN, 0, 0);
    wait_result(prev);
    chk("t2_sat_pos0", longint'(cap_data[0]), 64'sh7FFF_FFFF);
    chk("t2_sat_pos9", longint'(cap_data[9]), 64'sh7FFF_FFFF);
    for (int k = 0; k < NUM_CLASS; k++) begin w[k] = 8'sd127; bias[k] = 32'sh8000_0000; end
    prev = n_results;
    send_frame(-8'sd128, w, IN_LEN, 0, 0);
    wait_result(prev);
    chk("t2_sat_neg0", longint'(cap_data[0]), -64'sh8000_0000);
    chk("t2_sat_neg9", longint'(cap_data[9]), -64'sh8000_0000);

    // 3: short frame, count-closed frame, late last
    for (int k = 0; k < NUM_CLASS; k++) begin w[k] = 8'sd3; bias[k] = 32'(10 * k); end
    prev = n_results;
    send_frame(8'sd2, w, 50, 50, 0);
    wait_result(prev);
    chk("t3_short_data3", longint'(cap_data[3]), 330);
    chk("t3_short_err", longint'(cap_err), 1);
    prev = n_results;
    send_frame(8'sd2, w, IN_LEN, 0, 0);
    wait_result(prev);
    chk("t3_full_data3", longint'(cap_data[3]), 750);
    chk("t3_full_err", longint'(cap_err), 0);
    prev = n_results;
    send_frame(8'sd2, w, IN_LEN, 0, 0);
    wait_result(prev);
    chk("t3_late_data0", longint'(cap_data[0]), 720);
    chk("t3_late_err", longint'(cap_err), 0);
    prev = n_results;
    send_beat(8'sd2, w, 1, 0);
    wait_result(prev);
    chk("t3_beat121_data2", longint'(cap_data[2]), 26);
    chk("t3_beat121_err", longint'(cap_err), 1);

    // 4: random data, random lengths, 50% valid gaps, back-to-back frames
    for (int k = 0; k < NUM_CLASS; k++) bias[k] = 32'($urandom_range(0, 200000)) - 32'sd100000;
    prev = n_results;
    for (int f = 0; f < 5; f++) begin
      int last_at;
      last_at = $urandom_range(1, 130);
      for (int i = 1; i <= ((last_at > IN_LEN) ? IN_LEN : last_at); i++) begin
        for (int k = 0; k < NUM_CLASS; k++) w[k] = 8'($urandom);
        send_beat(8'($urandom), w, (i == last_at), 1);
      end
    end
    wait_result(n_results);
    repeat (8) @(posedge clk);
    #1;
    chk("t4_frames", longint'(n_results - prev), 5);

    // 5: reset mid-frame, then a clean frame
    for (int k = 0; k < NUM_CLASS; k++) begin w[k] = 8'(k + 1); bias[k] = '0; end
    prev = n_results;
    send_frame(8'sd1, w, 60, 0, 0);
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_abort_result", longint'(n_results - prev), 0);
    send_frame(8'sd1, w, IN_LEN, 0, 0);
    wait_result(prev);
    for (int k = 0; k < NUM_CLASS; k++) chk("t5_data", longint'(cap_data[k]), 120 * (k + 1));

    // 6: two frames with a planted winner in class 7, o_data held between
    for (int k = 0; k < NUM_CLASS; k++) w[k] = 8'(k);
    w[7] = 8'sd50;
    prev = n_results;
    send_frame(8'sd1, w, IN_LEN, 0, 0);
    wait_result(prev);
    chk("t6_f1_data7", longint'(cap_data[7]), 6000);
    chk("t6_f1_argmax", longint'(argmax()), 7);
    w[7] = -8'sd60;
    prev = n_results;
    send_frame(-8'sd1, w, IN_LEN, 0, 0);
    chk("t6_hold_data7", longint'(o_data[7]), 6000);
    chk("t6_hold_data4", longint'(o_data[4]), 480);
    wait_result(prev);
    chk("t6_f2_data4", longint'(cap_data[4]), -480);
    chk("t6_f2_data7", longint'(cap_data[7]), 7200);
    chk("t6_f2_argmax", longint'(argmax()), 7);

    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
